// File: rtl/uart_pkg.sv
// uart_pkg: shared constants and receiver state encoding for the UART link
package uart_pkg;
  localparam int OVERSAMPLE_DEF = 16;
  localparam int DATA_BITS_DEF = 8;
  localparam int FRAME_BITS = DATA_BITS_DEF + 2;
  typedef enum logic [2:0] {IDLE, START, DATA, STOP, BREAK} state_e;
endpackage

// File: rtl/sync_2ff.sv
// sync_2ff: two-flop synchroniser for a single asynchronous input, resets to 1
module sync_2ff (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);
  logic s1_q, s2_q;
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_q <= 1'b1;
      s2_q <= 1'b1;
    end else begin
      s1_q <= d;
      s2_q <= s1_q;
    end
  end
  assign q = s2_q;
endmodule

// File: rtl/uart_rx.sv
// uart_rx: oversampled 8N1 receiver with valid strobe, frame error flag and break handling
module uart_rx
  import uart_pkg::*;
#(
  parameter int OVERSAMPLE = OVERSAMPLE_DEF,
  parameter int DATA_BITS = DATA_BITS_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rx,
  input  logic                 os_tick,
  output logic [DATA_BITS-1:0] data,
  output logic                 valid,
  output logic                 frame_err,
  output logic                 busy
);
  localparam int TW = $clog2(OVERSAMPLE);
  localparam int BW = $clog2(DATA_BITS);
  localparam logic [TW-1:0] HALF = TW'(OVERSAMPLE / 2 - 1);
  localparam logic [TW-1:0] LAST = TW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] LAST_BIT = BW'(DATA_BITS - 1);
  logic rx_s;
  state_e state_q, state_d;
  logic [TW-1:0] tick_q, tick_d;
  logic [BW-1:0] bit_q, bit_d;
  logic [DATA_BITS-1:0] shift_q, shift_d, data_q, data_d;
  logic valid_q, valid_d, ferr_q, ferr_d;
  sync_2ff u_sync (
    .clk(clk),
    .rst(rst),
    .d  (rx),
    .q  (rx_s)
  );
  always_comb begin
    state_d = state_q;
    tick_d = tick_q;
    bit_d = bit_q;
    shift_d = shift_q;
    data_d = data_q;
    valid_d = 1'b0;
    ferr_d = 1'b0;
    if (os_tick) begin
      case (state_q)
        IDLE: begin
          state_d = rx_s ? IDLE : START;
          tick_d = '0;
        end
        START: begin
          tick_d = tick_q + TW'(1);
          if (tick_q == HALF) begin
            state_d = rx_s ? IDLE : DATA;
            tick_d = '0;
            bit_d = '0;
          end
        end
        DATA: begin
          tick_d = tick_q + TW'(1);
          if (tick_q == LAST) begin
            shift_d = {rx_s, shift_q[DATA_BITS-1:1]};
            tick_d = '0;
            state_d = (bit_q == LAST_BIT) ? STOP : DATA;
            bit_d = (bit_q == LAST_BIT) ? bit_q : bit_q + BW'(1);
          end
        end
        STOP: begin
          tick_d = tick_q + TW'(1);
          if (tick_q == LAST) begin
            tick_d = '0;
            state_d = rx_s ? IDLE : BREAK;
            data_d = rx_s ? shift_q : data_q;
            valid_d = rx_s;
            ferr_d = !rx_s;
          end
        end
        BREAK: state_d = rx_s ? IDLE : BREAK;
        default: state_d = IDLE;
      endcase
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      tick_q <= '0;
      bit_q <= '0;
      shift_q <= '0;
      data_q <= '0;
      valid_q <= 1'b0;
      ferr_q <= 1'b0;
    end else begin
      state_q <= state_d;
      tick_q <= tick_d;
      bit_q <= bit_d;
      shift_q <= shift_d;
      data_q <= data_d;
      valid_q <= valid_d;
      ferr_q <= ferr_d;
    end
  end
  assign data = data_q;
  assign valid = valid_q;
  assign frame_err = ferr_q;
  assign busy = state_q != IDLE;
endmodule
